// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if: byte stream in, parsed channel report and status out
interface uart_frame_parser_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [3:0]  ch_idx;
    logic [15:0] ch_value;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;
    modport master (output rx_data, rx_valid, input ch_idx, ch_value, frame_valid, frame_err, err_cnt, busy);
    modport slave  (input rx_data, rx_valid, output ch_idx, ch_value, frame_valid, frame_err, err_cnt, busy);
endinterface

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: parses "Vtu - dddd V<LF><CR>" frames into channel index/BCD value pulses
module uart_frame_parser #(
    parameter int NUM_CH         = 13,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic clk,
    input logic rst,
    uart_frame_parser_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic {HUNT, FIELD} state_t;
    state_t        r_state, w_state_n;
    logic [3:0]    r_pos, w_pos_n;
    logic [TW-1:0] r_timer;
    logic [3:0]    r_tens;
    logic [4:0]    r_chan;
    logic [15:0]   r_val;
    logic [3:0]    r_ch_idx;
    logic [15:0]   r_ch_value;
    logic          r_frame_valid, r_frame_err, r_busy;
    logic [7:0]    r_err_cnt;
    logic [7:0]    w_exp;
    logic [3:0]    w_dig;
    logic [4:0]    w_chan;
    logic          w_digit_pos, w_is_digit, w_is_v, w_match, w_commit, w_err, w_timeout;
    assign w_dig       = bus.rx_data[3:0];
    assign w_is_digit  = bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39;
    assign w_is_v      = bus.rx_data == 8'h56;
    // channel number deliberately wraps in 5 bits
    assign w_chan      = {1'b0, r_tens} * 5'd10 + {1'b0, w_dig};
    assign w_digit_pos = r_pos inside {4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9};
    assign w_exp       = (r_pos == 4'd3 || r_pos == 4'd5 || r_pos == 4'd10) ? 8'h20 :
                         r_pos == 4'd4  ? 8'h2D :
                         r_pos == 4'd11 ? 8'h56 :
                         r_pos == 4'd12 ? 8'h0A : 8'h0D;
    assign w_match     = (w_digit_pos ? w_is_digit : bus.rx_data == w_exp) &&
                         (r_pos != 4'd2 || (w_chan != 5'd0 && w_chan <= 5'(NUM_CH)));
    assign w_timeout   = r_state == FIELD && !bus.rx_valid && r_timer == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
            r_pos   <= 4'd0;
        end else begin
            r_state <= w_state_n;
            r_pos   <= w_pos_n;
        end
    end
    always_comb begin
        w_state_n = r_state;
        w_pos_n   = r_pos;
        w_commit  = 1'b0;
        w_err     = w_timeout;
        if (w_timeout) begin
            w_state_n = HUNT;
            w_pos_n   = 4'd0;
        end else if (bus.rx_valid) begin
            if (r_state == HUNT) begin
                w_state_n = w_is_v ? FIELD : HUNT;
                w_pos_n   = w_is_v ? 4'd1 : 4'd0;
            end else if (w_match) begin
                w_commit  = r_pos == 4'd13;
                w_state_n = w_commit ? HUNT : FIELD;
                w_pos_n   = w_commit ? 4'd0 : r_pos + 4'd1;
            end else begin
                w_err     = 1'b1;
                w_state_n = w_is_v ? FIELD : HUNT;
                w_pos_n   = w_is_v ? 4'd1 : 4'd0;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer       <= '0;
            r_tens        <= 4'd0;
            r_chan        <= 5'd0;
            r_val         <= 16'd0;
            r_ch_idx      <= 4'd0;
            r_ch_value    <= 16'd0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_err_cnt     <= 8'd0;
            r_busy        <= 1'b0;
        end else begin
            r_timer <= (bus.rx_valid || w_state_n == HUNT) ? '0 : r_timer + 1'b1;
            if (bus.rx_valid && r_state == FIELD) begin
                if (r_pos == 4'd1) r_tens <= w_dig;
                if (r_pos == 4'd2) r_chan <= w_chan;
                if (r_pos >= 4'd6 && r_pos <= 4'd9) r_val <= {r_val[11:0], w_dig};
            end
            if (w_commit) begin
                r_ch_idx   <= 4'(r_chan - 5'd1);
                r_ch_value <= r_val;
            end
            if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            r_frame_valid <= w_commit;
            r_frame_err   <= w_err;
            r_busy        <= w_state_n != HUNT;
        end
    end
    assign bus.ch_idx      = r_ch_idx;
    assign bus.ch_value    = r_ch_value;
    assign bus.frame_valid = r_frame_valid;
    assign bus.frame_err   = r_frame_err;
    assign bus.err_cnt     = r_err_cnt;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed frames checked every cycle against a frame-buffer model
module tb_uart_frame_parser;
    localparam int NCH = 13;
    localparam int T   = 40;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    uart_frame_parser_if bus();
    uart_frame_parser #(.NUM_CH(NCH), .TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_chk = 0;
    int n_fail = 0;
    int fv_seen = 0;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask
    logic [7:0]  q[$];
    int          idle_cnt = 0;
    logic [3:0]  e_idx = 4'd0;
    logic [15:0] e_val = 16'd0;
    logic        e_fv = 1'b0, e_fe = 1'b0, e_busy = 1'b0;
    int          e_cnt = 0;
    string       tmpl = "V## - #### V";
    function automatic bit fits(int p, logic [7:0] b);
        logic [7:0] c;
        int chan;
        if (p == 12) return b == 8'h0A;
        if (p == 13) return b == 8'h0D;
        c = tmpl[p];
        if (c != "#") return b == c;
        if (b < 8'h30 || b > 8'h39) return 0;
        if (p != 2) return 1;
        chan = ((q[1] - 48) * 10 + (b - 48)) % 32;
        return chan >= 1 && chan <= NCH;
    endfunction
    task automatic m_err();
        e_fe = 1'b1;
        if (e_cnt < 255) e_cnt++;
    endtask
    task automatic m_consume(logic [7:0] b);
        if (q.size() == 0) begin
            if (b == 8'h56) q.push_back(b);
        end else if (fits(q.size(), b)) begin
            q.push_back(b);
            if (q.size() == 14) begin
                e_fv  = 1'b1;
                e_idx = 4'(((q[1] - 48) * 10 + (q[2] - 48)) - 1);
                e_val = {q[6][3:0], q[7][3:0], q[8][3:0], q[9][3:0]};
                q.delete();
            end
        end else begin
            m_err();
            q.delete();
            if (b == 8'h56) q.push_back(b);
        end
    endtask
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            idle_cnt = 0;
            e_idx = 4'd0; e_val = 16'd0; e_fv = 1'b0; e_fe = 1'b0; e_busy = 1'b0; e_cnt = 0;
        end else begin
            e_fv = 1'b0;
            e_fe = 1'b0;
            if (bus.rx_valid) begin
                idle_cnt = 0;
                m_consume(bus.rx_data);
            end else if (q.size() > 0) begin
                idle_cnt++;
                if (idle_cnt == T) begin
                    m_err();
                    q.delete();
                end
            end
            e_busy = q.size() > 0;
        end
    end
    always @(negedge clk) begin
        chk("frame_valid", {31'd0, bus.frame_valid}, {31'd0, e_fv});
        chk("frame_err", {31'd0, bus.frame_err}, {31'd0, e_fe});
        chk("busy", {31'd0, bus.busy}, {31'd0, e_busy});
        chk("err_cnt", {24'd0, bus.err_cnt}, e_cnt);
        chk("ch_idx", {28'd0, bus.ch_idx}, {28'd0, e_idx});
        chk("ch_value", {16'd0, bus.ch_value}, {16'd0, e_val});
        chk("fv_fe_excl", {31'd0, bus.frame_valid & bus.frame_err}, 32'd0);
        if (bus.frame_valid === 1'b1) fv_seen++;
    end
    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send(logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask
    task automatic sends(string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask
    task automatic frame(string body);
        sends(body);
        send(8'h0A);
        send(8'h0D);
    endtask
    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        idle(3);
        rst = 1'b0;
        chk("rst_err_cnt", {24'd0, bus.err_cnt}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_ch_value", {16'd0, bus.ch_value}, 32'd0);
        frame("V05 - 1234 V");
        chk("t1_fv", {31'd0, bus.frame_valid}, 32'd1);
        chk("t1_idx", {28'd0, bus.ch_idx}, 32'd4);
        chk("t1_val", {16'd0, bus.ch_value}, 32'h1234);
        chk("t1_cnt", {24'd0, bus.err_cnt}, 32'd0);
        idle(1);
        chk("t1_fv_drop", {31'd0, bus.frame_valid}, 32'd0);
        send(8'h41);
        send(8'h0D);
        frame("V13 - 0987 V");
        chk("t2_idx", {28'd0, bus.ch_idx}, 32'd12);
        chk("t2_val", {16'd0, bus.ch_value}, 32'h0987);
        chk("t2_cnt", {24'd0, bus.err_cnt}, 32'd0);
        sends("V14");
        sends("V00");
        idle(1);
        chk("t3_cnt", {24'd0, bus.err_cnt}, 32'd2);
        chk("t3_fv_seen", fv_seen, 32'd2);
        frame("V01 - 12V02 - 0555 V");
        chk("t4_idx", {28'd0, bus.ch_idx}, 32'd1);
        chk("t4_val", {16'd0, bus.ch_value}, 32'h0555);
        chk("t4_cnt", {24'd0, bus.err_cnt}, 32'd3);
        sends("V03 - 1");
        idle(T - 1);
        chk("t5_pre_fe", {31'd0, bus.frame_err}, 32'd0);
        chk("t5_pre_busy", {31'd0, bus.busy}, 32'd1);
        idle(1);
        chk("t5_fe", {31'd0, bus.frame_err}, 32'd1);
        chk("t5_busy", {31'd0, bus.busy}, 32'd0);
        chk("t5_cnt", {24'd0, bus.err_cnt}, 32'd4);
        sends("V03 - 1");
        idle(T - 1);
        frame("234 V");
        chk("t5b_fv", {31'd0, bus.frame_valid}, 32'd1);
        chk("t5b_idx", {28'd0, bus.ch_idx}, 32'd2);
        chk("t5b_val", {16'd0, bus.ch_value}, 32'h1234);
        chk("t5b_cnt", {24'd0, bus.err_cnt}, 32'd4);
        sends("V05 - 12");
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        frame("V07 - 4321 V");
        chk("t6_idx", {28'd0, bus.ch_idx}, 32'd6);
        chk("t6_val", {16'd0, bus.ch_value}, 32'h4321);
        chk("t6_cnt", {24'd0, bus.err_cnt}, 32'd0);
        idle(1);
        chk("t6_fv_seen", fv_seen, 32'd5);
        repeat (300) sends("V00");
        idle(1);
        chk("t6_sat", {24'd0, bus.err_cnt}, 32'd255);
        chk("t6_fv_final", fv_seen, 32'd5);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
